mem_block_reader: RTL and testbench

MEM_BLOCK_READER -- requirements
Module: mem_block_reader

---
 rtl/mem_block_reader_pkg.sv | 14 +
 rtl/mem_block_reader_fifo.sv | 58 +++++
 rtl/mem_block_reader.sv | 136 +++++++++++++
 tb/tb_mem_block_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_block_reader_pkg.sv
// Shared types and default widths for the block reader.
package mem_block_reader_pkg;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mem_block_reader_fifo.sv
// Small show-ahead output FIFO with occupancy count. Head entry is visible
// combinationally; push and pop in the same cycle are legal even when full.
module mem_reader_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Storage slot: cleared on reset so the head reads zero when idle
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/mem_block_reader.sv
// Reads a block of consecutive words from a 1-cycle-latency on-chip memory
// and streams them out with sop/eop framing and full backpressure support.
module mem_block_reader
    import mem_block_reader_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = DATA_W + 2;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   remain_reg;
    logic              first_reg;
    logic              inflight_reg;
    logic              inflight_sop_reg;
    logic              inflight_eop_reg;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_rdata;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic [CW:0]       occ_after;

    // A read may only be issued if the FIFO is guaranteed room for its data,
    // counting the one read already in flight and any beat leaving this cycle.
    assign pop        = st_valid & st_ready;
    assign occ_after  = {1'b0, fifo_count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
    assign issue      = (state_reg == ST_READ) && (remain_reg != '0)
                        && (occ_after < (CW+1)'(FIFO_DEPTH));
    assign last_issue = issue && (remain_reg == (ADDR_W+1)'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = (length == '0) ? ST_FINISH : ST_READ;
            end
            ST_READ: begin
                if (last_issue) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && st_eop) state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode from state and issue condition
    always_comb begin
        busy           = (state_reg != ST_IDLE);
        done           = (state_reg == ST_FINISH);
        mem_chipselect = issue;
    end

    // Address/count bookkeeping and tagging of the read in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_reg         <= '0;
            remain_reg       <= '0;
            first_reg        <= 1'b0;
            inflight_reg     <= 1'b0;
            inflight_sop_reg <= 1'b0;
            inflight_eop_reg <= 1'b0;
        end else begin
            inflight_reg     <= issue;
            inflight_sop_reg <= first_reg;
            inflight_eop_reg <= (remain_reg == (ADDR_W+1)'(1));
            if ((state_reg == ST_IDLE) && start) begin
                addr_reg   <= start_addr;
                remain_reg <= length;
                first_reg  <= 1'b1;
            end else if (issue) begin
                addr_reg   <= addr_reg + 1'b1;
                remain_reg <= remain_reg - 1'b1;
                first_reg  <= 1'b0;
            end
        end
    end

    mem_reader_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight_reg),
        .wdata   ({mem_readdata, inflight_sop_reg, inflight_eop_reg}),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign mem_address    = addr_reg;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign st_valid       = !fifo_empty;
    assign st_data        = fifo_rdata[FW-1:2];
    assign st_sop         = fifo_rdata[1];
    assign st_eop         = fifo_rdata[0];

endmodule

// File: tb/tb_mem_block_reader.sv
// Directed bench for mem_block_reader with a beat scoreboard.
module tb_mem_block_reader;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int FD = 2;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_readdata;
    logic [DW-1:0] st_data;
    logic          st_valid, st_ready, st_sop, st_eop;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int beats    = 0;
    int done_cnt = 0;
    int last_eop_cyc = 0;
    bit last_eop_valid = 0;
    bit stall_prev = 0;
    logic [DW+1:0] held = '0;
    bit rdy_mode = 0;
    int ph = 0;

    mem_block_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_addr     (start_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return {4'hD, a, 4'h5, ~a};
    endfunction

    // Memory model: registered read, one cycle latency
    always @(posedge clk) begin
        mem_readdata <= memval(mem_address);
        cyc <= cyc + 1;
    end

    // Ready pattern driver (1,0,0,1 repeating when enabled)
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                st_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
        end
    end

    // Output monitor: scoreboard pops, stall stability, done timing, fifo bound
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall_prev) begin
                checks++;
                assert ({st_valid, st_data, st_sop, st_eop} === {1'b1, held}) else begin
                    failures++;
                    $error("FAIL stall_hold observed=%h expected=%h",
                           {st_valid, st_data, st_sop, st_eop}, {1'b1, held});
                end
            end
            stall_prev = st_valid && !st_ready;
            held = {st_data, st_sop, st_eop};
            if (st_valid && st_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL extra_beat observed=%h expected=none", st_data);
                end
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    checks++;
                    assert ({st_data, st_sop, st_eop} === e) else begin
                        failures++;
                        $error("FAIL beat observed=%h/%b%b expected=%h/%b%b",
                               st_data, st_sop, st_eop, e.data, e.sop, e.eop);
                    end
                end
                beats++;
                if (st_eop) begin
                    last_eop_cyc = cyc;
                    last_eop_valid = 1;
                end
            end
            if (done) begin
                done_cnt++;
                if (last_eop_valid) begin
                    checks++;
                    assert (cyc === last_eop_cyc + 1) else begin
                        failures++;
                        $error("FAIL done_timing observed=%0d expected=%0d", cyc, last_eop_cyc + 1);
                    end
                    last_eop_valid = 0;
                end
            end
            checks++;
            assert (int'(dut.fifo_count) <= FD) else begin
                failures++;
                $error("FAIL fifo_bound observed=%0d expected<=%0d", dut.fifo_count, FD);
            end
        end else begin
            stall_prev = 0;
            last_eop_valid = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] addr;
        for (int i = 0; i < len; i++) begin
            addr = a + AW'(i);
            exp_q.push_back(beat_t'{memval(addr), (i == 0), (i == len - 1)});
        end
    endtask

    // Drives a one-cycle start; returns at the negedge of the first READ cycle
    task automatic do_start(input logic [AW-1:0] a, input int len);
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        length = (AW+1)'(len);
        push_exp(a, len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n = 0;
        #1;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("busy_cleared", 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {busy, done, st_valid, st_sop, st_eop, mem_chipselect},   64'd0);
        chk({tag, "_addr"}, 64'(mem_address), 64'd0);
        chk({tag, "_data"}, 64'(st_data), 64'd0);
    endtask

    initial begin
        int d0, b0, n;
        reset_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        length = '0;
        st_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("tieoffs", {mem_write, mem_byteenable, mem_clken}, 64'b0_1111_1);
        reset_n = 1'b1;

        // Basic block, checks first-read timing and first-valid latency
        d0 = done_cnt; b0 = beats;
        do_start(12'h010, 4);
        chk("first_cs", 64'(mem_chipselect), 64'd1);
        chk("first_addr", 64'(mem_address), 64'h010);
        chk("busy_high", 64'(busy), 64'd1);
        @(negedge clk);
        chk("valid_cyc2", 64'(st_valid), 64'd0);
        @(negedge clk);
        chk("valid_cyc3", 64'(st_valid), 64'd1);
        chk("sop_cyc3", 64'(st_sop), 64'd1);
        wait_done(d0, 50);
        chk("beats_len4", 64'(beats - b0), 64'd4);
        $display("txn1 addr=010 len=4 beats=%0d", beats - b0);

        // Address wrap
        d0 = done_cnt; b0 = beats;
        do_start(12'hFFE, 4);
        wait_done(d0, 50);
        chk("beats_wrap", 64'(beats - b0), 64'd4);
        $display("txn2 addr=FFE len=4 beats=%0d", beats - b0);

        // Backpressure with ready pattern 1,0,0,1
        d0 = done_cnt; b0 = beats;
        ph = 0; rdy_mode = 1;
        do_start(12'h200, 8);
        wait_done(d0, 200);
        rdy_mode = 0; st_ready = 1'b1;
        chk("beats_bp", 64'(beats - b0), 64'd8);
        $display("txn3 addr=200 len=8 backpressure beats=%0d", beats - b0);

        // Single beat
        d0 = done_cnt; b0 = beats;
        do_start(12'h7FF, 1);
        wait_done(d0, 50);
        chk("beats_len1", 64'(beats - b0), 64'd1);
        $display("txn4 addr=7FF len=1 beats=%0d", beats - b0);

        // Zero length: done the next cycle, no beats, single pulse
        d0 = done_cnt; b0 = beats;
        do_start(12'h123, 0);
        chk("len0_done_next", 64'(done), 64'd1);
        wait_done(d0, 10);
        repeat (5) @(negedge clk);
        #1;
        chk("len0_done_once", 64'(done_cnt - d0), 64'd1);
        chk("len0_no_beats", 64'(beats - b0), 64'd0);
        $display("txn5 addr=123 len=0 done_pulses=%0d", done_cnt - d0);

        // Start during busy must be ignored
        d0 = done_cnt; b0 = beats;
        do_start(12'h300, 4);
        start = 1'b1; start_addr = 12'h400; length = 13'd8;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, 50);
        repeat (4) @(negedge clk);
        #1;
        chk("busy_start_beats", 64'(beats - b0), 64'd4);
        chk("busy_start_done", 64'(done_cnt - d0), 64'd1);
        $display("txn6 addr=300 len=4 with ignored start beats=%0d", beats - b0);

        // Reset after beat 2 of a 16-beat block
        d0 = done_cnt; b0 = beats;
        do_start(12'h100, 16);
        n = 0;
        #1;
        while ((beats - b0) < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached_beat2", 64'(beats - b0), 64'd3);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_reset_outputs("midreset");
        #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midreset_no_beats", 64'(beats - b0), 64'd3);
        $display("txn7 addr=100 len=16 aborted beats=%0d", beats - b0);

        d0 = done_cnt; b0 = beats;
        do_start(12'h020, 3);
        wait_done(d0, 50);
        chk("after_reset_beats", 64'(beats - b0), 64'd3);
        $display("txn8 addr=020 len=3 beats=%0d", beats - b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
